// File: rtl/ldtu_packer_param_if.sv
`default_nettype none
// ============================================================================
// Module   : ldtu_packer_param_if
// Purpose  : Bundles the sample input, control strobes and the output
//            ready/valid FIFO port of the LiTe-DTU style packer.
// Ports    : master - sample producer / word consumer (drives sample side,
//                     out_ready; observes data_out, out_valid, level, overflow)
//            slave  - the packer itself
// Revision : 1.0 - initial release
// ============================================================================
interface ldtu_packer_param_if #(
  parameter int NB_SIG = 13,
  parameter int WORD   = 32,
  parameter int LW     = 3
);
  logic              sample_valid;
  logic [NB_SIG-1:0] sample;
  logic              baseline_flag;
  logic              Orbit;
  logic              fallback;
  logic [WORD-1:0]   data_out;
  logic              out_valid;
  logic              out_ready;
  logic [LW-1:0]     fifo_level;
  logic              overflow;

  modport master (
    output sample_valid, sample, baseline_flag, Orbit, fallback, out_ready,
    input  data_out, out_valid, fifo_level, overflow
  );

  modport slave (
    input  sample_valid, sample, baseline_flag, Orbit, fallback, out_ready,
    output data_out, out_valid, fifo_level, overflow
  );
endinterface
`default_nettype wire

// File: rtl/ldtu_packer_param.sv
`default_nettype none
// ============================================================================
// Module   : ldtu_packer_param
// Purpose  : Packs 13-bit ADC samples into fixed-width words (baseline
//            groups, signal pairs, orbit headers, fallback raw pairs) and
//            queues them in a DEPTH-entry output FIFO with sticky overflow.
// Ports    : CLK   - clock
//            rst_b - asynchronous active-low reset
//            bus   - ldtu_packer_param_if.slave (samples in, words out)
// Revision : 1.0 - initial release
// ============================================================================
module ldtu_packer_param #(
  parameter int                NB_BAS  = 6,
  parameter int                MAX_BAS = 5,
  parameter int                NB_SIG  = 13,
  parameter int                DEPTH   = 4,
  parameter logic [NB_SIG-1:0] HDR     = 13'b1111000001111,
  parameter logic [NB_SIG-1:0] SYNC    = 13'b0101010101010
) (
  input  wire logic           CLK,
  input  wire logic           rst_b,
  ldtu_packer_param_if.slave  bus
);
  localparam int WORD = 2 + MAX_BAS * NB_BAS;
  localparam int CS   = WORD - 2 * NB_SIG;
  localparam int BW   = MAX_BAS * NB_BAS;
  localparam int CW   = $clog2(MAX_BAS + 1);
  localparam int LW   = $clog2(DEPTH + 1);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_BAS  = 3'd1;
  localparam logic [2:0] ST_SIG1 = 3'd2;
  localparam logic [2:0] ST_FB0  = 3'd3;
  localparam logic [2:0] ST_FB1  = 3'd4;

  if (CS < 6) begin : g_bad_cfg
    $error("ldtu_packer_param: WORD-2*NB_SIG must be >= 6");
  end

  logic [2:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BW-1:0]     buf_q, buf_d;
  logic [NB_SIG-1:0] sig_q, sig_d;
  logic              orb_q, orb_d;
  logic              fb_q;
  logic [WORD-1:0]   mem_q [DEPTH];
  logic [WORD-1:0]   mem_d [DEPTH];
  logic [LW-1:0]     lvl_q, lvl_d;
  logic              ovf_q, ovf_d;

  // A fallback edge discards any partial group: the sample seen on that
  // cycle is processed from the fresh state of the new mode.
  logic [2:0]        w_cur;
  logic              w_orb;
  logic [NB_BAS-1:0] w_b;
  logic [BW-1:0]     w_ins;
  logic [WORD-1:0]   w_part, w_full, w_pair, w_one, w_hdr, w_fb;
  logic              w_emit0, w_emit1;
  logic [WORD-1:0]   w_word0, w_word1;

  assign w_cur = (bus.fallback != fb_q) ? (bus.fallback ? ST_FB0 : ST_IDLE) : state_q;
  assign w_orb = bus.Orbit | orb_q;
  assign w_b   = bus.sample[NB_BAS-1:0];

  // Baseline buffer with the current sample inserted at slot n (slot 0 when
  // a new group starts, in which case older contents are cleared).
  always_comb begin
    w_ins = (w_cur == ST_BAS) ? buf_q : '0;
    for (int k = 0; k < MAX_BAS; k++) begin
      if (((w_cur == ST_BAS) && (cnt_q == CW'(k))) || ((w_cur != ST_BAS) && (k == 0)))
        w_ins[k*NB_BAS +: NB_BAS] = w_b;
    end
  end

  // Partial group: n sits in the top NB_BAS bits of the data field; the
  // unused slots below it are already zero in the buffer.
  assign w_part = {2'b10, buf_q} | (WORD'(cnt_q) << (WORD - 2 - NB_BAS));
  assign w_full = {2'b01, w_ins};
  assign w_pair = {CS'(6'b001010), bus.sample, sig_q};
  assign w_one  = {CS'(6'b001011), SYNC, sig_q};
  assign w_hdr  = {CS'(6'b001011), HDR, bus.sample};
  assign w_fb   = {{(CS-2){1'b1}}, ~^bus.sample, ~^sig_q, bus.sample, sig_q};

  // State register and datapath registers
  always_ff @(posedge CLK or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      buf_q   <= '0;
      sig_q   <= '0;
      orb_q   <= 1'b0;
      fb_q    <= 1'b0;
      lvl_q   <= '0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      sig_q   <= sig_d;
      orb_q   <= orb_d;
      fb_q    <= bus.fallback;
      lvl_q   <= lvl_d;
      ovf_q   <= ovf_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  // Next-state logic
  always_comb begin
    state_d = w_cur;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    sig_d   = sig_q;
    orb_d   = bus.fallback ? 1'b0 : w_orb;
    if (bus.sample_valid) begin
      orb_d = 1'b0;
      if (bus.fallback) begin
        if (w_cur == ST_FB1) begin
          state_d = ST_FB0;
        end else begin
          sig_d   = bus.sample;
          state_d = ST_FB1;
        end
      end else if (w_orb) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else begin
        case (w_cur)
          ST_BAS: begin
            if (!bus.baseline_flag) begin
              sig_d   = bus.sample;
              cnt_d   = '0;
              state_d = ST_SIG1;
            end else if (cnt_q == CW'(MAX_BAS - 1)) begin
              cnt_d   = '0;
              state_d = ST_IDLE;
            end else begin
              buf_d = w_ins;
              cnt_d = cnt_q + CW'(1);
            end
          end
          ST_SIG1, ST_IDLE: begin
            if (!bus.baseline_flag) begin
              sig_d   = bus.sample;
              state_d = (w_cur == ST_SIG1) ? ST_IDLE : ST_SIG1;
            end else if (MAX_BAS == 1) begin
              state_d = ST_IDLE;
            end else begin
              buf_d   = w_ins;
              cnt_d   = CW'(1);
              state_d = ST_BAS;
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end
  end

  // Output logic: up to two words per cycle, word0 always written first
  always_comb begin
    w_emit0 = 1'b0;
    w_emit1 = 1'b0;
    w_word0 = '0;
    w_word1 = '0;
    if (bus.sample_valid) begin
      if (bus.fallback) begin
        if (w_cur == ST_FB1) begin
          w_emit0 = 1'b1;
          w_word0 = w_fb;
        end
      end else if (w_orb) begin
        w_emit0 = 1'b1;
        case (w_cur)
          ST_BAS:  begin w_word0 = w_part; w_emit1 = 1'b1; w_word1 = w_hdr; end
          ST_SIG1: begin w_word0 = w_one;  w_emit1 = 1'b1; w_word1 = w_hdr; end
          default: w_word0 = w_hdr;
        endcase
      end else begin
        case (w_cur)
          ST_IDLE: if (bus.baseline_flag && (MAX_BAS == 1)) begin
            w_emit0 = 1'b1;
            w_word0 = w_full;
          end
          ST_BAS: begin
            if (!bus.baseline_flag) begin
              w_emit0 = 1'b1;
              w_word0 = w_part;
            end else if (cnt_q == CW'(MAX_BAS - 1)) begin
              w_emit0 = 1'b1;
              w_word0 = w_full;
            end
          end
          ST_SIG1: begin
            w_emit0 = 1'b1;
            w_word0 = bus.baseline_flag ? w_one : w_pair;
            if (bus.baseline_flag && (MAX_BAS == 1)) begin
              w_emit1 = 1'b1;
              w_word1 = w_full;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Output FIFO: head is always mem_q[0]; a pop shifts the queue down, then
  // new words land right after the surviving entries.
  always_comb begin
    int n_req, base, space, n_acc;
    logic pop;
    pop   = (lvl_q != '0) && bus.out_ready;
    n_req = int'(w_emit0) + int'(w_emit1);
    base  = int'(lvl_q) - (pop ? 1 : 0);
    space = DEPTH - base;
    n_acc = (n_req < space) ? n_req : space;
    ovf_d = ovf_q | (n_req > space);
    for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
    if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++) mem_d[i] = mem_q[i+1];
      mem_d[DEPTH-1] = '0;
    end
    if (n_acc >= 1) mem_d[base]   = w_word0;
    if (n_acc >= 2) mem_d[base+1] = w_word1;
    lvl_d = LW'(base + n_acc);
  end

  assign bus.data_out   = mem_q[0];
  assign bus.out_valid  = (lvl_q != '0);
  assign bus.fifo_level = lvl_q;
  assign bus.overflow   = ovf_q;
endmodule
`default_nettype wire

// File: tb/tb_ldtu_packer_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_ldtu_packer_param
// Purpose  : Directed self-checking bench for ldtu_packer_param: baseline
//            full/partial words, signal pairs, orbit flush + header,
//            fallback pairs, FIFO overflow and asynchronous reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ldtu_packer_param;
  logic CLK = 1'b0;
  logic rst_b;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 CLK = ~CLK;

  ldtu_packer_param_if #(.NB_SIG(13), .WORD(32), .LW(3)) bus ();

  ldtu_packer_param dut (
    .CLK   (CLK),
    .rst_b (rst_b),
    .bus   (bus)
  );

  // Inputs change 1 time unit after a rising edge; outputs are read there too.
  task automatic send(input logic bf, input logic [12:0] s, input logic orb);
    bus.sample_valid  = 1'b1;
    bus.baseline_flag = bf;
    bus.sample        = s;
    bus.Orbit         = orb;
    @(posedge CLK); #1;
    bus.sample_valid  = 1'b0;
    bus.Orbit         = 1'b0;
  endtask

  task automatic pop_one();
    bus.out_ready = 1'b1;
    @(posedge CLK); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid); end
    n_chk++; if (bus.fifo_level !== 3'd0) begin n_fail++; $display("FAIL reset_level got=%0d exp=0", bus.fifo_level); end
    n_chk++; if (bus.data_out !== 32'h0) begin n_fail++; $display("FAIL reset_data got=%h exp=00000000", bus.data_out); end
    n_chk++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got=%b exp=0", bus.overflow); end
  endtask

  task automatic test_baseline_full();
    bus.out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      send(1'b1, 13'(k), 1'b0);
      n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bas_early_%0d got=%b exp=0", k, bus.out_valid); end
    end
    send(1'b1, 13'h05, 1'b0);
    n_chk++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bas_valid got=%b exp=1", bus.out_valid); end
    n_chk++; if (bus.data_out !== 32'h45103081) begin n_fail++; $display("FAIL bas_full got=%h exp=45103081", bus.data_out); end
    @(posedge CLK); #1;
    n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bas_popped got=%b exp=0", bus.out_valid); end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_sig_pair();
    send(1'b0, 13'h123, 1'b0);
    n_chk++; if (bus.fifo_level !== 3'd0) begin n_fail++; $display("FAIL pair_half got=%0d exp=0", bus.fifo_level); end
    send(1'b0, 13'h456, 1'b0);
    n_chk++; if (bus.data_out !== 32'h288AC123) begin n_fail++; $display("FAIL sig_pair got=%h exp=288AC123", bus.data_out); end
    n_chk++; if (bus.fifo_level !== 3'd1) begin n_fail++; $display("FAIL pair_level got=%0d exp=1", bus.fifo_level); end
    pop_one();
  endtask

  task automatic test_bas_part();
    send(1'b1, 13'h0A, 1'b0);
    send(1'b1, 13'h0B, 1'b0);
    send(1'b0, 13'h100, 1'b0);
    n_chk++; if (bus.data_out !== 32'h820002CA) begin n_fail++; $display("FAIL bas_part got=%h exp=820002CA", bus.data_out); end
    send(1'b0, 13'h200, 1'b0);
    n_chk++; if (bus.fifo_level !== 3'd2) begin n_fail++; $display("FAIL part_level got=%0d exp=2", bus.fifo_level); end
    pop_one();
    n_chk++; if (bus.data_out !== 32'h28400100) begin n_fail++; $display("FAIL held_pair got=%h exp=28400100", bus.data_out); end
    pop_one();
  endtask

  task automatic test_orbit();
    send(1'b0, 13'h123, 1'b0);
    send(1'b1, 13'h0AA, 1'b1);
    n_chk++; if (bus.fifo_level !== 3'd2) begin n_fail++; $display("FAIL orb_level got=%0d exp=2", bus.fifo_level); end
    n_chk++; if (bus.data_out !== 32'h2D554123) begin n_fail++; $display("FAIL orb_sig_one got=%h exp=2D554123", bus.data_out); end
    pop_one();
    n_chk++; if (bus.data_out !== 32'h2FC1E0AA) begin n_fail++; $display("FAIL orb_header got=%h exp=2FC1E0AA", bus.data_out); end
    pop_one();
    // Orbit pulse without a sample is latched until the next valid sample.
    bus.Orbit = 1'b1;
    @(posedge CLK); #1;
    bus.Orbit = 1'b0;
    @(posedge CLK); #1;
    send(1'b0, 13'h055, 1'b0);
    n_chk++; if (bus.fifo_level !== 3'd1) begin n_fail++; $display("FAIL orb_latch_lvl got=%0d exp=1", bus.fifo_level); end
    n_chk++; if (bus.data_out !== 32'h2FC1E055) begin n_fail++; $display("FAIL orb_latch_hdr got=%h exp=2FC1E055", bus.data_out); end
    pop_one();
    send(1'b1, 13'h03, 1'b0);
    send(1'b0, 13'h1FFF, 1'b1);
    n_chk++; if (bus.data_out !== 32'h81000003) begin n_fail++; $display("FAIL orb_part got=%h exp=81000003", bus.data_out); end
    pop_one();
    n_chk++; if (bus.data_out !== 32'h2FC1FFFF) begin n_fail++; $display("FAIL orb_hdr2 got=%h exp=2FC1FFFF", bus.data_out); end
    pop_one();
  endtask

  task automatic test_fallback();
    bus.fallback = 1'b1;
    send(1'b0, 13'h0001, 1'b0);
    n_chk++; if (bus.fifo_level !== 3'd0) begin n_fail++; $display("FAIL fb_half got=%0d exp=0", bus.fifo_level); end
    send(1'b1, 13'h0003, 1'b0);
    n_chk++; if (bus.data_out !== 32'hF8006001) begin n_fail++; $display("FAIL fb_pair got=%h exp=F8006001", bus.data_out); end
    pop_one();
    send(1'b0, 13'h1FFF, 1'b1);
    send(1'b0, 13'h0000, 1'b0);
    n_chk++; if (bus.fifo_level !== 3'd1) begin n_fail++; $display("FAIL fb_orb_lvl got=%0d exp=1", bus.fifo_level); end
    n_chk++; if (bus.data_out !== 32'hF8001FFF) begin n_fail++; $display("FAIL fb_parity got=%h exp=F8001FFF", bus.data_out); end
    pop_one();
    // Leave a half pair pending, then drop fallback: it must be discarded.
    send(1'b0, 13'h0007, 1'b0);
    bus.fallback = 1'b0;
    send(1'b0, 13'h111, 1'b0);
    send(1'b0, 13'h222, 1'b0);
    n_chk++; if (bus.fifo_level !== 3'd1) begin n_fail++; $display("FAIL fb_exit_lvl got=%0d exp=1", bus.fifo_level); end
    n_chk++; if (bus.data_out !== 32'h28444111) begin n_fail++; $display("FAIL fb_exit got=%h exp=28444111", bus.data_out); end
    pop_one();
  endtask

  task automatic test_overflow();
    logic [31:0] exp_w;
    for (int k = 1; k <= 5; k++) begin
      send(1'b0, 13'(k), 1'b0);
      send(1'b0, 13'(16 + k), 1'b0);
      if (k == 4) begin
        n_chk++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_early got=%b exp=0", bus.overflow); end
      end
    end
    n_chk++; if (bus.fifo_level !== 3'd4) begin n_fail++; $display("FAIL ovf_level got=%0d exp=4", bus.fifo_level); end
    n_chk++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got=%b exp=1", bus.overflow); end
    for (int k = 1; k <= 4; k++) begin
      exp_w = 32'h28000000 | (32'(16 + k) << 13) | 32'(k);
      n_chk++; if (bus.data_out !== exp_w) begin n_fail++; $display("FAIL ovf_word_%0d got=%h exp=%h", k, bus.data_out, exp_w); end
      if (k < 4) pop_one();
    end
    // Asynchronous reset between edges clears everything immediately.
    rst_b = 1'b0;
    #1;
    n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_valid got=%b exp=0", bus.out_valid); end
    n_chk++; if (bus.fifo_level !== 3'd0) begin n_fail++; $display("FAIL arst_level got=%0d exp=0", bus.fifo_level); end
    n_chk++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL arst_ovf got=%b exp=0", bus.overflow); end
    n_chk++; if (bus.data_out !== 32'h0) begin n_fail++; $display("FAIL arst_data got=%h exp=00000000", bus.data_out); end
  endtask

  initial begin
    rst_b             = 1'b0;
    bus.sample_valid  = 1'b0;
    bus.sample        = '0;
    bus.baseline_flag = 1'b0;
    bus.Orbit         = 1'b0;
    bus.fallback      = 1'b0;
    bus.out_ready     = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    test_reset();
    rst_b = 1'b1;
    @(posedge CLK); #1;
    test_baseline_full();
    test_sig_pair();
    test_bas_part();
    test_orbit();
    test_fallback();
    test_overflow();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
